// File: rtl/acc_cpu_core.sv
// acc_cpu_core: parametrised accumulator CPU with one accumulator (A), PC,
// instruction register and N/Z flags, fetching and accessing data over an
// external single-port req/ack memory bus that may insert any number of waits.
module acc_cpu_core #(
  parameter int unsigned              DATA_W   = 16,
  parameter int unsigned              ADDR_W   = 12,
  parameter logic [ADDR_W-1:0]        RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] acc_o,
  output logic [1:0]        flags_o
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_LD  = 4'h0,
    OP_ADD = 4'h1,
    OP_JMP = 4'h2,
    OP_ST  = 4'h3,
    OP_CMP = 4'h4,
    OP_JEQ = 4'h5,
    OP_SUB = 4'h6,
    OP_JLT = 4'h7,
    OP_LDI = 4'h8,
    OP_AND = 4'h9,
    OP_OR  = 4'hA,
    OP_HLT = 4'hF
  } opcode_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [DATA_W-1:0]   acc_q;
  // IR is kept as its two decoded fields only; the bits between the operand
  // and the opcode carry no meaning and are not stored.
  opcode_e             ir_op_q;
  logic [ADDR_W-1:0]   ir_c_q;
  logic                n_q;
  logic                z_q;
  logic                req_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                halted_q;

  logic                is_mem_d;
  logic [DATA_W-1:0]   imm_d;

  // Classify the current instruction and form the zero-extended immediate.
  always_comb begin
    is_mem_d = 1'b0;
    imm_d    = {{(DATA_W-ADDR_W){1'b0}}, ir_c_q};
    case (ir_op_q)
      OP_LD, OP_ADD, OP_ST, OP_CMP, OP_SUB, OP_AND, OP_OR: is_mem_d = 1'b1;
      default:                                             is_mem_d = 1'b0;
    endcase
  end

  // Control FSM and datapath; the bus request is raised in the cycle after a
  // state is entered and is held with stable address/data until ack.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      acc_q    <= '0;
      ir_op_q  <= OP_LD;
      ir_c_q   <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (!req_q) begin
            if (run) begin
              req_q  <= 1'b1;
              we_q   <= 1'b0;
              addr_q <= pc_q;
            end
          end else if (mem_ack) begin
            ir_op_q <= opcode_e'(mem_rdata[DATA_W-1 -: 4]);
            ir_c_q  <= mem_rdata[ADDR_W-1:0];
            pc_q    <= pc_q + ADDR_W'(1);
            req_q   <= 1'b0;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!req_q) begin
            if (is_mem_d) begin
              req_q   <= 1'b1;
              we_q    <= (ir_op_q == OP_ST);
              addr_q  <= ir_c_q;
              wdata_q <= acc_q;
            end else begin
              state_q <= S_FETCH;
              case (ir_op_q)
                OP_JMP: pc_q <= ir_c_q;
                OP_JEQ: if (z_q) pc_q <= ir_c_q;
                OP_JLT: if (n_q) pc_q <= ir_c_q;
                OP_LDI: acc_q <= imm_d;
                OP_HLT: begin
                  state_q  <= S_HALT;
                  halted_q <= 1'b1;
                end
                default: ;
              endcase
            end
          end else if (mem_ack) begin
            case (ir_op_q)
              OP_LD:  acc_q <= mem_rdata;
              OP_ADD: acc_q <= acc_q + mem_rdata;
              OP_SUB: acc_q <= acc_q - mem_rdata;
              OP_AND: acc_q <= acc_q & mem_rdata;
              OP_OR:  acc_q <= acc_q | mem_rdata;
              OP_CMP: begin
                n_q <= ($signed(acc_q) < $signed(mem_rdata));
                z_q <= (acc_q == mem_rdata);
              end
              default: ;
            endcase
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= S_FETCH;
          end
        end
        S_HALT: begin
          req_q    <= 1'b0;
          halted_q <= 1'b1;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign halted    = halted_q;
  assign pc_o      = pc_q;
  assign acc_o     = acc_q;
  assign flags_o   = {n_q, z_q};

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: a bus-level memory model with programmable wait
// states, an instruction-level reference model producing the expected bus
// transfer sequence and final architectural state, and directed programs.
module tb_acc_cpu_core;

  localparam int DW   = 16;
  localparam int AW   = 12;
  localparam int MEMN = 4096;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          run     = 1'b0;
  logic          mem_req, mem_we, mem_ack, halted;
  logic [AW-1:0] mem_addr, pc_o;
  logic [DW-1:0] mem_wdata, mem_rdata, acc_o;
  logic [1:0]    flags_o;

  acc_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(12'h000)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .run      (run),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .halted   (halted),
    .pc_o     (pc_o),
    .acc_o    (acc_o),
    .flags_o  (flags_o)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [MEMN];
  logic [DW-1:0] img [MEMN];
  logic          do_load   = 1'b0;
  logic          stray_ack = 1'b0;
  int            waits     = 0;
  int            wait_cnt  = 0;

  assign mem_ack   = (mem_req && (wait_cnt == waits)) || stray_ack;
  assign mem_rdata = mem[mem_addr];

  always @(posedge clock) begin
    if (do_load) begin
      for (int i = 0; i < MEMN; i++) mem[i] <= img[i];
    end else if (mem_req && mem_ack && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  // ---------------- instruction-level reference model ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic          fetch;
    logic [AW-1:0] pc;
    logic [DW-1:0] acc;
    logic [1:0]    fl;
  } xfer_t;

  xfer_t         xq[$];
  logic [DW-1:0] m_acc;
  logic [AW-1:0] m_pc;
  logic [1:0]    m_fl;
  int            m_cycles, m_nreq, m_stores;

  task automatic build_model();
    logic [DW-1:0] mm [MEMN];
    logic [DW-1:0] a, ir, rd;
    logic [AW-1:0] pc, c;
    logic [3:0]    op;
    logic          n, z, hlt;
    xfer_t         t;
    xq.delete();
    for (int i = 0; i < MEMN; i++) mm[i] = img[i];
    a = '0; pc = '0; n = 1'b0; z = 1'b0; hlt = 1'b0;
    m_cycles = 0; m_nreq = 0; m_stores = 0;
    for (int step = 0; step < 5000 && !hlt; step++) begin
      t.addr = pc; t.we = 1'b0; t.wdata = '0; t.fetch = 1'b1;
      t.pc = pc; t.acc = a; t.fl = {n, z};
      xq.push_back(t);
      m_nreq++; m_cycles += 2;
      ir = mm[pc];
      pc = pc + 12'd1;
      op = ir[15:12];
      c  = ir[11:0];
      if (op inside {4'h0, 4'h1, 4'h3, 4'h4, 4'h6, 4'h9, 4'hA}) begin
        t.addr = c; t.we = (op == 4'h3); t.wdata = a; t.fetch = 1'b0;
        xq.push_back(t);
        m_nreq++; m_cycles += 2;
        rd = mm[c];
        case (op)
          4'h0: a = rd;
          4'h1: a = a + rd;
          4'h3: begin mm[c] = a; m_stores++; end
          4'h4: begin n = ($signed(a) < $signed(rd)); z = (a == rd); end
          4'h6: a = a - rd;
          4'h9: a = a & rd;
          4'hA: a = a | rd;
          default: ;
        endcase
      end else begin
        m_cycles += 1;
        case (op)
          4'h2: pc = c;
          4'h5: if (z) pc = c;
          4'h7: if (n) pc = c;
          4'h8: a = {4'h0, c};
          4'hF: hlt = 1'b1;
          default: ;
        endcase
      end
    end
    m_cycles += waits * m_nreq;
    m_acc = a; m_pc = pc; m_fl = {n, z};
  endtask

  // ---------------- compare process ----------------
  logic          chk_en = 1'b0;
  logic          pend   = 1'b0;
  logic [AW-1:0] s_addr;
  logic          s_we;
  logic [DW-1:0] s_wdata;
  int            st_seen = 0;

  always @(negedge clock) begin
    xfer_t t;
    if (chk_en && reset_n) begin
      if (pend && mem_req)
        chk("bus_stable", {3'b0, mem_addr, mem_we, mem_wdata}, {3'b0, s_addr, s_we, s_wdata});
      if (mem_req && mem_ack) begin
        if (xq.size() == 0) begin
          chk("xfer_expected", 32'(xq.size()), 32'd1);
        end else begin
          t = xq.pop_front();
          chk("xfer_addr", 32'(mem_addr), 32'(t.addr));
          chk("xfer_we", 32'(mem_we), 32'(t.we));
          if (t.we) chk("xfer_wdata", 32'(mem_wdata), 32'(t.wdata));
          if (t.fetch) begin
            chk("fetch_pc", 32'(pc_o), 32'(t.pc));
            chk("fetch_acc", 32'(acc_o), 32'(t.acc));
            chk("fetch_flags", 32'(flags_o), 32'(t.fl));
          end
        end
        if (mem_we) st_seen <= st_seen + 1;
        pend <= 1'b0;
      end else if (mem_req) begin
        if (!pend) begin
          s_addr  <= mem_addr;
          s_we    <= mem_we;
          s_wdata <= mem_wdata;
        end
        pend <= 1'b1;
      end else begin
        pend <= 1'b0;
      end
    end else begin
      pend <= 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_img();
    for (int i = 0; i < MEMN; i++) img[i] = '0;
  endtask

  task automatic load_mem();
    reset_n = 1'b0;
    run     = 1'b0;
    chk_en  = 1'b0;
    @(negedge clock);
    do_load = 1'b1;
    @(negedge clock);
    do_load = 1'b0;
  endtask

  // Runs the image with the given wait states; run stays low for run_delay
  // cycles after reset release. cyc counts rising edges from run=1 to halt.
  task automatic run_prog(input string nm, input int w, input int run_delay, output int cyc);
    logic saw_req;
    waits = w;
    load_mem();
    build_model();
    st_seen = 0;
    @(negedge clock);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    saw_req = 1'b0;
    for (int i = 0; i < run_delay; i++) begin
      @(negedge clock);
      if (mem_req) saw_req = 1'b1;
    end
    if (run_delay > 0) chk({nm, "_no_req_while_run0"}, 32'(saw_req), 32'd0);
    run = 1'b1;
    cyc = 0;
    while (!halted && cyc < 3000) begin
      @(posedge clock);
      cyc++;
      #1;
    end
    chk({nm, "_halted"}, 32'(halted), 32'd1);
    @(negedge clock);
    chk({nm, "_acc"}, 32'(acc_o), 32'(m_acc));
    chk({nm, "_pc"}, 32'(pc_o), 32'(m_pc));
    chk({nm, "_flags"}, 32'(flags_o), 32'(m_fl));
    chk({nm, "_xfers_left"}, 32'(xq.size()), 32'd0);
    chk({nm, "_stores"}, 32'(st_seen), 32'(m_stores));
    chk({nm, "_cycles"}, 32'(cyc), 32'(m_cycles));
    chk({nm, "_halt_req"}, 32'(mem_req), 32'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int c0, c3, cx, guard;

    // Reset values.
    clear_img();
    load_mem();
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc", 32'(pc_o), 32'd0);
    chk("rst_acc", 32'(acc_o), 32'd0);
    chk("rst_flags", 32'(flags_o), 32'd0);

    // LDI 5; ADD @0x20 (=3); ST @0x21; HLT -- zero wait states.
    clear_img();
    img[0] = 16'h8005; img[1] = 16'h1020; img[2] = 16'h3021; img[3] = 16'hF000;
    img[12'h020] = 16'h0003;
    run_prog("basic", 0, 0, c0);
    chk("basic_m21", 32'(mem[12'h021]), 32'h8);
    // halted first seen after the 14th edge, i.e. cycle 13 counting from 0
    chk("basic_halt_cycle", 32'(c0), 32'd14);
    chk("basic_acc_lit", 32'(acc_o), 32'h8);
    chk("basic_pc_lit", 32'(pc_o), 32'h4);

    // Same program, three wait states per request (6 requests).
    run_prog("wait3", 3, 0, c3);
    chk("wait3_m21", 32'(mem[12'h021]), 32'h8);
    chk("wait3_cycles_lit", 32'(c3), 32'(c0 + 3 * 6));
    chk("wait3_acc_lit", 32'(acc_o), 32'h8);

    // Counter loop: increment M[0x20] until it equals 10.
    clear_img();
    img[0] = 16'h0020; img[1] = 16'h1022; img[2] = 16'h3020; img[3] = 16'h4023;
    img[4] = 16'h5006; img[5] = 16'h2000; img[6] = 16'hF000;
    img[12'h022] = 16'h0001; img[12'h023] = 16'h000A;
    run_prog("loop", 0, 0, cx);
    chk("loop_acc_lit", 32'(acc_o), 32'hA);
    chk("loop_flags_lit", 32'(flags_o), 32'b01);
    chk("loop_stores_lit", 32'(st_seen), 32'd10);
    chk("loop_m20", 32'(mem[12'h020]), 32'hA);

    // Signed compare -1 vs 1, JEQ not taken, JLT taken, then OR/AND/SUB.
    clear_img();
    img[0] = 16'h0020; img[1] = 16'h4021; img[2] = 16'h500A; img[3] = 16'h7005;
    img[4] = 16'hF000; img[5] = 16'h8055; img[6] = 16'hA022; img[7] = 16'h9023;
    img[8] = 16'h6024; img[9] = 16'hF000; img[10] = 16'h80EE; img[11] = 16'hF000;
    img[12'h020] = 16'hFFFF; img[12'h021] = 16'h0001; img[12'h022] = 16'h0F00;
    img[12'h023] = 16'h0FF0; img[12'h024] = 16'h0F51;
    run_prog("signed", 1, 0, cx);
    chk("signed_acc_lit", 32'(acc_o), 32'hFFFF);
    chk("signed_flags_lit", 32'(flags_o), 32'b10);
    chk("signed_pc_lit", 32'(pc_o), 32'hA);

    // PC wrap: NOP at 0xFFF falls through to address 0.
    clear_img();
    img[0] = 16'h5003; img[1] = 16'h4020; img[2] = 16'h2FFF; img[3] = 16'hF000;
    img[12'hFFF] = 16'hB000;
    run_prog("wrap", 0, 0, cx);
    chk("wrap_pc_lit", 32'(pc_o), 32'h4);
    chk("wrap_flags_lit", 32'(flags_o), 32'b01);

    // Overflow 0x7FFF + 1 with run held low for a while after reset.
    clear_img();
    img[0] = 16'h0020; img[1] = 16'h1021; img[2] = 16'hF000;
    img[12'h020] = 16'h7FFF; img[12'h021] = 16'h0001;
    run_prog("ovf", 2, 8, cx);
    chk("ovf_acc_lit", 32'(acc_o), 32'h8000);
    chk("ovf_flags_lit", 32'(flags_o), 32'b00);

    // Reset while ST waits for ack.
    clear_img();
    img[0] = 16'h8007; img[1] = 16'h3030; img[2] = 16'hF000;
    img[12'h030] = 16'h1234;
    waits = 10;
    load_mem();
    @(negedge clock);
    reset_n = 1'b1;
    run     = 1'b1;
    guard   = 0;
    while (!(mem_req && mem_we) && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    chk("abort_st_seen", 32'(mem_req && mem_we), 32'd1);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_req_async", 32'(mem_req), 32'd0);
    chk("abort_pc", 32'(pc_o), 32'd0);
    chk("abort_acc", 32'(acc_o), 32'd0);
    run = 1'b0;
    @(negedge clock);
    reset_n   = 1'b1;
    stray_ack = 1'b1;
    repeat (2) @(negedge clock);
    stray_ack = 1'b0;
    @(negedge clock);
    chk("abort_m30", 32'(mem[12'h030]), 32'h1234);
    chk("abort_pc_after", 32'(pc_o), 32'd0);
    chk("abort_acc_after", 32'(acc_o), 32'd0);
    chk("abort_req_after", 32'(mem_req), 32'd0);
    chk("abort_halted", 32'(halted), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
